mpx_irq_ctrl: RTL and testbench

MPX_IRQ_CTRL -- requirements
Module: mpx_irq_ctrl

---
 rtl/mpx_irq_ctrl_pkg.sv | 8 +
 rtl/mpx_irq_edge.sv | 24 ++
 rtl/mpx_irq_ctrl.sv | 92 +++++++++
 tb/tb_mpx_irq_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mpx_irq_ctrl_pkg.sv
// Shared MPX interrupt-controller definitions: register offsets and default source count.
package mpx_irq_ctrl_pkg;

  localparam int         IRQ_W_DEF = 11;
  localparam logic [3:0] ADDR_STAT = 4'h0;
  localparam logic [3:0] ADDR_MASK = 4'h4;

endpackage

// File: rtl/mpx_irq_edge.sv
// Rising-edge detector for a vector of level interrupt sources; history clears on reset
// so a level already high when reset releases is reported as a fresh edge.
module mpx_irq_edge #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] src_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] src_d, src_q;

  always_comb begin
    src_d  = src_i;
    rise_o = src_i & ~src_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) src_q <= '0;
    else       src_q <= src_d;
  end

endmodule

// File: rtl/mpx_irq_ctrl.sv
// MPX interrupt controller: edge-latched I_STAT with acknowledge-only writes, I_MASK,
// and one registered CPU interrupt line built from the pending masked sources.
module mpx_irq_ctrl
  import mpx_irq_ctrl_pkg::*;
#(
  parameter int IRQ_W       = IRQ_W_DEF,
  parameter int CPU_INT_BIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IRQ_W-1:0] irq_src_i,
  input  logic             req_valid_i,
  input  logic             req_write_i,
  input  logic [3:0]       req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_wstrb_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic [5:0]       intr_o
);

  logic [IRQ_W-1:0] rise;
  logic [IRQ_W-1:0] bm;
  logic [IRQ_W-1:0] stat_d, stat_q;
  logic [IRQ_W-1:0] mask_d, mask_q;
  logic [31:0]      rdata_d, rdata_q;
  logic             resp_d, resp_q;
  logic             intr_d, intr_q;
  logic             unused_req;

  assign unused_req = ^{req_wdata_i, req_wstrb_i};

  mpx_irq_edge #(.W(IRQ_W)) u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .src_i  (irq_src_i),
    .rise_o (rise)
  );

  always_comb begin
    bm = '0;
    for (int i = 0; i < IRQ_W; i++) bm[i] = req_wstrb_i[i/8];

    stat_d  = stat_q;
    mask_d  = mask_q;
    rdata_d = '0;
    resp_d  = req_valid_i;

    if (req_valid_i && req_write_i) begin
      // Writing 1 to I_STAT is a no-op; only strobed zeros acknowledge.
      if (req_addr_i == ADDR_STAT)
        stat_d = stat_q & ~(bm & ~req_wdata_i[IRQ_W-1:0]);
      else if (req_addr_i == ADDR_MASK)
        mask_d = (mask_q & ~bm) | (req_wdata_i[IRQ_W-1:0] & bm);
    end

    // Reads see the registers as they stood before this cycle's updates.
    if (req_valid_i && !req_write_i) begin
      if (req_addr_i == ADDR_STAT)      rdata_d = 32'(stat_q);
      else if (req_addr_i == ADDR_MASK) rdata_d = 32'(mask_q);
    end

    // A new edge overrides a same-cycle acknowledge.
    stat_d = stat_d | rise;
    intr_d = |(stat_q & mask_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      stat_q  <= stat_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      intr_q  <= intr_d;
    end
  end

  always_comb begin
    intr_o              = '0;
    intr_o[CPU_INT_BIT] = intr_q;
  end

  assign resp_valid_o = resp_q;
  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_mpx_irq_ctrl.sv
// Directed bench for mpx_irq_ctrl: latency, acknowledge, set-wins, held level, mask, reset.
module tb_mpx_irq_ctrl;

  localparam int IRQ_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic [IRQ_W-1:0] irq_src;
  logic             req_valid, req_write;
  logic [3:0]       req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic [5:0]       intr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpx_irq_ctrl #(.IRQ_W(IRQ_W), .CPU_INT_BIT(0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_src_i    (irq_src),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wstrb_i  (req_wstrb),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .intr_o       (intr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data; req_wstrb = strb;
    tick();
    chk("wr_resp", 32'(resp_valid), 32'd1);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    tick();
    chk({tag, "_resp"}, 32'(resp_valid), 32'd1);
    chk(tag, resp_rdata, exp);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = '0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    tick(); tick();
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    rd("rst_stat", 4'h0, 32'h0);
    rd("rst_mask", 4'h4, 32'h0);

    // Edge latency: edge at N, I_STAT at N+1, intr at N+2
    wr(4'h4, 32'h1, 4'hF);
    irq_src[0] = 1'b1;
    tick();
    chk("lat_intr_n1", 32'(intr), 32'd0);
    rd("lat_stat_n1", 4'h0, 32'h001);
    chk("lat_intr_n2", 32'(intr), 32'h01);
    rd("lat_mask", 4'h4, 32'h001);

    // Acknowledge I_STAT=0x005
    irq_src[2] = 1'b1;
    tick();
    rd("ack_pre", 4'h0, 32'h005);
    wr(4'h0, 32'hFFFF_FFFA, 4'hF);
    chk("ack_intr_n1", 32'(intr), 32'h01);
    tick();
    chk("ack_intr_n2", 32'(intr), 32'h00);
    rd("ack_stat", 4'h0, 32'h000);

    // Held level does not re-set; toggle does
    tick(); tick();
    rd("held_stat", 4'h0, 32'h000);
    irq_src[2] = 1'b0; tick();
    rd("held_low", 4'h0, 32'h000);
    irq_src[2] = 1'b1; tick();
    rd("held_retoggle", 4'h0, 32'h004);
    wr(4'h0, 32'h0, 4'hE);
    rd("strb_skip", 4'h0, 32'h004);
    wr(4'h0, 32'h0, 4'h1);
    rd("strb_clr", 4'h0, 32'h000);

    // Set wins over same-cycle acknowledge
    irq_src[1] = 1'b1; tick();
    rd("sw_pre", 4'h0, 32'h002);
    irq_src[3] = 1'b1;
    wr(4'h0, 32'h0, 4'hF);
    rd("sw_stat", 4'h0, 32'h008);

    // Mask and read
    wr(4'h0, 32'h0, 4'hF);
    irq_src[4] = 1'b1;
    wr(4'h4, 32'h0, 4'hF);
    tick();
    chk("msk_intr_off", 32'(intr), 32'h00);
    rd("msk_stat", 4'h0, 32'h010);
    wr(4'h4, 32'hFFFF, 4'hF);
    chk("msk_intr_n1", 32'(intr), 32'h00);
    tick();
    chk("msk_intr_n2", 32'(intr), 32'h01);
    rd("msk_read", 4'h4, 32'h7FF);
    rd("unmapped_rd", 4'h8, 32'h0);
    wr(4'h8, 32'h0, 4'hF);
    rd("unmapped_stat", 4'h0, 32'h010);
    rd("unmapped_mask", 4'h4, 32'h7FF);
    wr(4'h4, 32'h0, 4'h2);
    rd("msk_partial", 4'h4, 32'h0FF);
    wr(4'h4, 32'h7FF, 4'hF);

    // Reset mid-operation
    irq_src = '0; tick();
    irq_src = 11'h7FF; tick();
    tick();
    chk("mid_intr", 32'(intr), 32'h01);
    rd("mid_stat", 4'h0, 32'h7FF);
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h0;
    tick();
    chk("mid_rst_resp", 32'(resp_valid), 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    chk("mid_rst_intr", 32'(intr), 32'd0);
    req_valid = 1'b0; rst = 1'b0;
    tick();
    chk("post_rst_resp", 32'(resp_valid), 32'd0);
    rd("post_rst_stat", 4'h0, 32'h7FF);
    rd("post_rst_mask", 4'h4, 32'h0);
    chk("post_rst_intr", 32'(intr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
